// File: rtl/spi_pkg.sv
// spi_pkg: frame width, register map and FSM states shared by the SPI peripheral.
package spi_pkg;
    localparam int FRAME_W = 16;
    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer with a history flop producing rise/fall pulses.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end
    assign o_level = r_sync[STAGES-1];
    assign o_rise  = o_level & ~r_prev;
    assign o_fall  = ~o_level & r_prev;
endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI write-only register file of five 8-bit control registers.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);
    logic w_sclk_rise, w_unused_sclk_lvl, w_unused_sclk_fall;
    logic w_copi, w_unused_copi_rise, w_unused_copi_fall;
    logic w_ncs_lvl, w_ncs_rise, w_ncs_fall;
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .i_d(sclk),
        .o_level(w_unused_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_unused_sclk_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
        .clk(clk), .rst(rst), .i_d(copi),
        .o_level(w_copi), .o_rise(w_unused_copi_rise), .o_fall(w_unused_copi_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
        .clk(clk), .rst(rst), .i_d(ncs),
        .o_level(w_ncs_lvl), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
    );
    state_t                 r_state, w_next;
    logic [4:0]             r_cnt;
    logic [FRAME_W-1:0]     r_shift;
    logic [7:0]             r_regs [5];
    logic                   r_strobe;
    logic [SYNC_STAGES-1:0] r_warm;
    logic                   r_armed;
    logic                   w_start, w_shift_en, w_wr;
    logic [6:0]             w_addr;
    assign w_addr = r_shift[14:8];
    // r_armed blocks a frame until ncs is seen high once the synchronizer holds real pin values.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_shift_en = 1'b0;
        w_wr       = 1'b0;
        case (r_state)
            ST_IDLE:   w_next = (w_ncs_fall && r_armed) ? ST_SHIFT : ST_IDLE;
            ST_SHIFT:  w_next = w_ncs_rise ? ST_COMMIT : ST_SHIFT;
            default:   w_next = ST_IDLE;
        endcase
        w_start    = (r_state == ST_IDLE) && (w_next == ST_SHIFT);
        w_shift_en = (r_state == ST_SHIFT) && w_sclk_rise && !w_ncs_lvl;
        w_wr       = (r_state == ST_COMMIT) && (r_cnt == 5'(FRAME_W)) && r_shift[FRAME_W-1]
                     && (w_addr <= MAX_ADDR) && (w_addr <= ADDR_PWM_DUTY);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_regs   <= '{default: 8'h00};
            r_strobe <= 1'b0;
            r_warm   <= '0;
            r_armed  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_strobe <= w_wr;
            r_warm   <= {r_warm[SYNC_STAGES-2:0], 1'b1};
            r_armed  <= r_armed | (r_warm[SYNC_STAGES-1] & w_ncs_lvl);
            if (w_start) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (w_shift_en) begin
                r_shift <= {r_shift[FRAME_W-2:0], w_copi};
                r_cnt   <= (r_cnt == 5'(FRAME_W + 1)) ? r_cnt : r_cnt + 5'd1;
            end
            if (w_wr) r_regs[w_addr[2:0]] <= r_shift[7:0];
        end
    end
    assign en_reg_out_7_0  = r_regs[0];
    assign en_reg_out_15_8 = r_regs[1];
    assign en_reg_pwm_7_0  = r_regs[2];
    assign en_reg_pwm_15_8 = r_regs[3];
    assign pwm_duty_cycle  = r_regs[4];
    assign wr_strobe       = r_strobe;
endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per SPI input pin (minimum 2).
REQ-002 SHALL have parameter MAX_ADDR, default 7'h04: highest writable register address.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port sclk, input, 1 bit: SPI clock from the host, asynchronous to clk.
REQ-006 SHALL have port copi, input, 1 bit: SPI data from the host, asynchronous to clk.
REQ-007 SHALL have port ncs, input, 1 bit: SPI chip select, active-low, asynchronous to clk.
REQ-008 SHALL have port en_reg_out_7_0, output, 8 bits: register at address 0x00, output enables for out[7:0].
REQ-009 SHALL have port en_reg_out_15_8, output, 8 bits: register at address 0x01, output enables for out[15:8].
REQ-010 SHALL have port en_reg_pwm_7_0, output, 8 bits: register at address 0x02, PWM enables for out[7:0].
REQ-011 SHALL have port en_reg_pwm_15_8, output, 8 bits: register at address 0x03, PWM enables for out[15:8].
REQ-012 SHALL have port pwm_duty_cycle, output, 8 bits: register at address 0x04, PWM duty cycle.
REQ-013 SHALL have port wr_strobe, output, 1 bit: one-cycle pulse on the cycle after a register is updated.

Function
REQ-014 SHALL pass sclk, copi and ncs each through SYNC_STAGES flops, plus one history flop for edge detection on sclk and ncs.
REQ-015 SHALL detect a sclk rise when the previous synchronized value is 0 and the current one is 1; ncs fall and ncs rise are detected the same way.
REQ-016 SHALL use a frame format of 16 bits, MSB first: bit15 is R/W (1 = write), bits14:8 are a 7-bit address, bits7:0 are data.
REQ-017 SHALL implement states IDLE, SHIFT, COMMIT; reset state is IDLE.
REQ-018 SHALL go from IDLE to SHIFT on an ncs fall, clearing the 5-bit bit counter and the 16-bit shift register.
REQ-019 SHALL, in SHIFT, on each sclk rise while ncs is low, shift synchronized copi into the LSB and increment the counter, saturating at 17.
REQ-020 SHALL go from SHIFT to COMMIT on an ncs rise.
REQ-021 SHALL write data to the addressed register in COMMIT only if counter == 16, R/W == 1 and address <= MAX_ADDR, then return to IDLE; COMMIT lasts exactly one cycle.
REQ-022 SHALL discard frames that have fewer or more than 16 bits, R/W = 0, or an address above MAX_ADDR: no register changes and no wr_strobe.
REQ-023 SHALL raise wr_strobe for exactly one clk cycle, on the cycle after the write takes effect, and only for committed frames.
REQ-024 SHALL ignore a sclk rise that coincides with an ncs rise (sample not shifted).
REQ-025 SHALL ignore sclk activity while ncs is high or while in IDLE.
REQ-026 SHALL, when ncs is already low on leaving reset, wait in IDLE for an ncs rise followed by a fall before accepting a frame.
REQ-027 SHALL keep unaddressed registers unchanged across a write.
REQ-028 SHALL allow back-to-back frames separated by ncs high for at least 2 clk cycles.

Reset
REQ-029 SHALL, while rst = 1 at a clk edge, clear all five registers to 8'h00, clear wr_strobe to 0, and set state to IDLE, counter to 0 and shift register to 0.
REQ-030 SHALL reset the ncs synchronizer and history flops to 1, and the sclk and copi synchronizer flops to 0.
REQ-031 SHALL abort any in-progress frame when rst is asserted mid-frame, with no partial write.

Structure
REQ-032 SHALL place the register address constants (ADDR_EN_OUT_7_0 = 0x00 through ADDR_PWM_DUTY = 0x04), the state enumeration and the frame width of 16 in a shared package, spi_pkg.
REQ-033 SHALL implement the synchronizer as one sub-module, sync_edge, instantiated per input, which outputs the synchronized level plus rise and fall pulses.

Verification
REQ-034 SHALL test a write: frame 0x8055 -> en_reg_out_7_0 = 0x55 and a single wr_strobe pulse; all other registers stay 0x00.
REQ-035 SHALL test a write to the last address: frame 0x84C0 -> pwm_duty_cycle = 0xC0; then frame 0x0412 (a read) -> pwm_duty_cycle stays 0xC0 and there is no wr_strobe.
REQ-036 SHALL test address and length errors: frame 0x85AA (address 5) -> no change; a 15-bit frame and a 17-bit frame to address 0x02 -> en_reg_pwm_7_0 stays 0x00.
REQ-037 SHALL test reset mid-frame: assert rst after 9 bits of frame 0x83FF -> all registers 0x00; the next full frame 0x83FF -> en_reg_pwm_15_8 = 0xFF.
REQ-038 SHALL test back-to-back frames: 0x8001 then 0x8102 with a 2-cycle ncs gap -> en_reg_out_7_0 = 0x01, en_reg_out_15_8 = 0x02, and exactly two wr_strobe pulses.
